// File: rtl/baud_tick_gen.sv
// Baud-rate enable generator: turns a captured divisor into a 16x oversample
// tick (rx_en) and a 1x bit tick (tx_en), all in the system clock domain.
module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_buf,
    input  logic             buf_rdy,
    output logic             rx_en,
    output logic             tx_en,
    output logic             running,
    output logic             div_err
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic             rdy_q;
    logic             err_q, err_d;
    logic             capture;
    logic             cnt_zero;

    assign capture  = buf_rdy & ~rdy_q;
    assign cnt_zero = (cnt_q == '0);

    // A capture always takes priority over the period reload on the same edge.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        os_d    = os_q;
        err_d   = err_q;
        if (capture) begin
            if (div_buf == '0) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                state_d = RUN;
                div_d   = div_buf;
                cnt_d   = div_buf - DIV_W'(1);
                os_d    = '0;
                err_d   = 1'b0;
            end
        end else if (state_q == RUN) begin
            if (cnt_zero) begin
                cnt_d = div_q - DIV_W'(1);
                os_d  = os_q + OS_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            os_q    <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            os_q    <= os_d;
            rdy_q   <= buf_rdy;
            err_q   <= err_d;
        end
    end

    assign running = (state_q == RUN);
    assign rx_en   = running & cnt_zero;
    assign tx_en   = rx_en & (os_q == OS_W'(OVERSAMPLE - 1));
    assign div_err = err_q;

endmodule
